// File: rtl/pc_sequencer.sv
// Program-counter sequencer: +4 fetch, branch/jump redirect, exception entry and eret return.
// Define PC_SEQ_DELAY_SLOT_EN to get MIPS-style branch-delay-slot sequencing.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        eret,
  input  logic        exc_req,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] epc,
  output logic        in_slot,
  output logic        exc_bd
);

  typedef enum logic {RUN, SLOT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] redirect;

  // Jump wins over a simultaneous taken branch; targets are always word aligned.
  assign redirect = (jump ? jump_target : br_target) & 32'hFFFF_FFFC;
  assign pc_plus4 = pc_q + 32'd4;
  assign pc       = pc_q;
  assign epc      = epc_q;

`ifdef PC_SEQ_DELAY_SLOT_EN
  logic [31:0] tgt_q, tgt_d;
  logic        exc_bd_q, exc_bd_d;

  assign in_slot = (state_q == SLOT);
  assign exc_bd  = exc_bd_q;
`else
  assign in_slot = 1'b0;
  assign exc_bd  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    epc_d    = epc_q;
`ifdef PC_SEQ_DELAY_SLOT_EN
    tgt_d    = tgt_q;
    exc_bd_d = exc_bd_q;
`endif
    case (state_q)
      RUN: begin
        if (exc_req) begin
          pc_d  = EXC_VECTOR;
          epc_d = pc_q;
`ifdef PC_SEQ_DELAY_SLOT_EN
          exc_bd_d = 1'b0;
`endif
        end else if (stall) begin
          pc_d = pc_q;
        end else if (eret) begin
          pc_d = epc_q;
        end else if (jump || br_taken) begin
`ifdef PC_SEQ_DELAY_SLOT_EN
          tgt_d   = redirect;
          pc_d    = pc_plus4;
          state_d = SLOT;
`else
          pc_d    = redirect;
`endif
        end else begin
          pc_d = pc_plus4;
        end
      end
`ifdef PC_SEQ_DELAY_SLOT_EN
      SLOT: begin
        // Exception in the delay slot reports the branch itself so it is re-executed.
        if (exc_req) begin
          pc_d     = EXC_VECTOR;
          epc_d    = pc_q - 32'd4;
          exc_bd_d = 1'b1;
          tgt_d    = 32'd0;
          state_d  = RUN;
        end else if (!stall) begin
          pc_d    = tgt_q;
          state_d = RUN;
        end
      end
`endif
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      epc_q    <= 32'd0;
`ifdef PC_SEQ_DELAY_SLOT_EN
      tgt_q    <= 32'd0;
      exc_bd_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      epc_q    <= epc_d;
`ifdef PC_SEQ_DELAY_SLOT_EN
      tgt_q    <= tgt_d;
      exc_bd_q <= exc_bd_d;
`endif
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;

`ifdef PC_SEQ_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, br_taken, jump, eret, exc_req;
  logic [31:0] br_target, jump_target;
  logic [31:0] pc, pc_plus4, epc;
  logic        in_slot, exc_bd;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_pc, m_epc;
  logic        m_bd;
  logic [31:0] pend[$];

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .jump(jump), .jump_target(jump_target), .eret(eret), .exc_req(exc_req),
    .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .in_slot(in_slot), .exc_bd(exc_bd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
    check({tag, ".epc"}, epc, m_epc);
    check({tag, ".in_slot"}, {31'd0, in_slot}, {31'd0, (pend.size() != 0)});
    check({tag, ".exc_bd"}, {31'd0, exc_bd}, {31'd0, m_bd});
  endtask

  task automatic model_reset();
    m_pc  = RST_PC;
    m_epc = 32'd0;
    m_bd  = 1'b0;
    pend.delete();
  endtask

  // A non-empty pending queue means the current pc is a delay-slot fetch.
  task automatic model_step(input logic s, input logic b, input logic [31:0] bt,
                            input logic j, input logic [31:0] jt, input logic e, input logic x);
    logic [31:0] t;
    if (pend.size() != 0) begin
      if (x) begin
        m_epc = m_pc - 32'd4;
        m_bd  = 1'b1;
        m_pc  = EXC_PC;
        pend.delete();
      end else if (!s) begin
        m_pc = pend.pop_front();
      end
    end else begin
      if (x) begin
        m_epc = m_pc;
        m_bd  = 1'b0;
        m_pc  = EXC_PC;
      end else if (s) begin
        m_pc = m_pc;
      end else if (e) begin
        m_pc = m_epc;
      end else if (j || b) begin
        t = j ? jt : bt;
        t[1:0] = 2'b00;
        if (DS) begin
          pend.push_back(t);
          m_pc = m_pc + 32'd4;
        end else begin
          m_pc = t;
        end
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic step(input string tag, input logic s, input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt, input logic e, input logic x);
    stall = s; br_taken = b; br_target = bt; jump = j; jump_target = jt; eret = e; exc_req = x;
    @(posedge clk);
    model_step(s, b, bt, j, jt, e, x);
    #1;
    check_all(tag);
    stall = 0; br_taken = 0; jump = 0; eret = 0; exc_req = 0;
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 32'd0, 0, 32'd0, 0, 0);
  endtask

  // Asserts reset between clock edges, checks the immediate effect, then releases it.
  task automatic async_reset(input string tag);
    #1 reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    check({tag, ".pc_const"}, pc, RST_PC);
    #1 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    stall = 0; br_taken = 0; jump = 0; eret = 0; exc_req = 0;
    br_target = 0; jump_target = 0;
    model_reset();
    #12;
    check_all("reset");
    check("reset.pc_const", pc, RST_PC);
    reset = 1'b1;

    idle("seq0");
    idle("seq1");
    step("br", 0, 1, 32'h0000_3103, 0, 32'd0, 0, 0);
    idle("br_slot");
    idle("br_after");

    idle("pre_jb");
    step("jump_br", 0, 1, 32'h0000_3300, 1, 32'h0000_3200, 0, 0);
    for (int i = 0; i < 3; i++) step("slot_stall", 1, 0, 32'd0, 0, 32'd0, 0, 0);
    idle("slot_release");

    step("br2", 0, 1, 32'h0000_3500, 0, 32'd0, 0, 0);
    step("slot_exc", 0, 0, 32'd0, 0, 32'd0, 0, 1);
    step("eret", 0, 0, 32'd0, 0, 32'd0, 1, 0);
    idle("after_eret");

    step("exc_stall", 1, 0, 32'd0, 0, 32'd0, 0, 1);
    step("stall_run", 1, 0, 32'd0, 0, 32'd0, 1, 0);

    step("jump_wrap", 0, 0, 32'd0, 1, 32'hFFFF_FFF9, 0, 0);
    for (int i = 0; i < 4; i++) idle("wrap");

    step("br_rst", 0, 1, 32'h0000_3700, 0, 32'd0, 0, 0);
    async_reset("rst_slot");
    idle("post_rst");

    for (int i = 0; i < 600; i++) begin
      logic s, b, j, e, x;
      s = ($urandom_range(0, 99) < 20);
      b = ($urandom_range(0, 99) < 12);
      j = ($urandom_range(0, 99) < 10);
      e = ($urandom_range(0, 99) < 6);
      x = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 2) begin
        async_reset("rand_rst");
      end else begin
        step("rand", s, b, $urandom, j, $urandom, e, x);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and decides its next value each cycle: sequential +4, branch/jump redirect, exception entry and eret return.
- Contains the PC register itself and sits between decode/branch-compare logic and the instruction memory address.
- Implements MIPS-style branch-delay-slot sequencing, stall hold and EPC capture with a two-state FSM.

Parameters:
RESET_PC  32'h00003000  PC value loaded on reset
EXC_VECTOR  32'h00004180  exception entry address

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset
stall  input  1  hold PC, FSM and pending target this cycle
br_taken  input  1  conditional branch resolved taken for instruction at pc
br_target  input  32  branch target address
jump  input  1  unconditional jump (j/jal/jr) for instruction at pc
jump_target  input  32  jump target address
eret  input  1  return from exception
exc_req  input  1  exception/interrupt request against instruction at pc
pc  output  32  current fetch address
pc_plus4  output  32  pc + 4, combinational
epc  output  32  saved exception PC
in_slot  output  1  high when pc is a delay-slot instruction (state SLOT)
exc_bd  output  1  last exception was taken in a delay slot

Behaviour:
- reset low (async): pc=RESET_PC, epc=0, exc_bd=0, pending target=0, state=RUN, in_slot=0. First posedge after release performs a normal update.
- pc_plus4 = pc+4 modulo 2^32; 32'hFFFFFFFC wraps to 0.
- Targets are stored with bits [1:0] forced to 2'b00.
- States: RUN (normal fetch), SLOT (fetching delay slot; target pending). in_slot = (state==SLOT).
- RUN, priority order per posedge:
  1. exc_req: pc<=EXC_VECTOR; epc<=pc; exc_bd<=0; stay RUN.
  2. stall: hold everything.
  3. eret: pc<=epc; stay RUN. No delay slot.
  4. jump or br_taken: target<=jump ? jump_target : br_target. Jump wins if both are asserted. pc<=pc+4; go to SLOT.
  5. Otherwise pc<=pc+4.
- SLOT, priority order per posedge:
  1. exc_req: pc<=EXC_VECTOR; epc<=pc-4 (the branch address); exc_bd<=1; discard target; go to RUN.
  2. stall: hold everything, including the pending target.
  3. Otherwise pc<=target; go to RUN.
  - jump, br_taken and eret are ignored in SLOT (branch in a delay slot is unsupported).
- exc_req overrides stall in both states.
- epc changes only on exception entry. exc_bd changes only on exception entry.
- Reset asserted mid-SLOT: pending target is lost and pc returns to RESET_PC.

Optional Feature:
- Macro: PC_SEQ_DELAY_SLOT_EN.
- Defined: delay-slot behaviour exactly as above.
- Undefined: jump/br_taken in RUN (not stalled, no exc_req) loads pc<=target directly. SLOT is never entered; in_slot and exc_bd are tied 0. Exceptions always save epc<=pc.

Test Plan:
- Reset, then release, no requests -> pc=3000, 3004, 3008 on successive posedges; pc_plus4 always pc+4.
- At pc=3008 pulse br_taken with br_target=3103 -> next pc=300C with in_slot=1, then pc=3100 with in_slot=0.
- At pc=3008 pulse jump(target 3200) and br_taken(target 3300) together, then hold stall 3 cycles while in SLOT -> pc stays 300C for the stall cycles, then 3200.
- In SLOT at pc=300C assert exc_req -> pc=4180, epc=3008, exc_bd=1; following eret -> pc=3008.
- In RUN at pc=3010 assert exc_req together with stall -> pc=4180, epc=3010, exc_bd=0.
- Set pc near 32'hFFFFFFF8 via jump, let it run -> pc goes ...FFFC then 0. Also assert reset asynchronously between clocks while in SLOT -> pc=3000 immediately, in_slot=0.
